// File: rtl/mc_control_if.sv
// Control-side bundle between the multicycle controller and its datapath/memory.
// The controller takes the master modport; the datapath side takes the slave modport.
interface mc_control_if #(
    parameter int RET_CNT_W = 32
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 mem_ready;
    logic                 trap_clr;
    logic                 mem_req;
    logic                 iord;
    logic                 mem_write;
    logic                 ir_write;
    logic                 pc_write;
    logic                 branch;
    logic                 branch_ne;
    logic                 reg_write;
    logic                 alu_src_a;
    logic [2:0]           alu_src_b;
    logic [3:0]           alu_control;
    logic [2:0]           pc_src;
    logic [2:0]           reg_dst;
    logic [2:0]           mem_to_reg;
    logic                 shift;
    logic                 jump_reg;
    logic                 trap;
    logic [4:0]           state_o;
    logic [RET_CNT_W-1:0] retired;

    modport master (
        input  op, funct, mem_ready, trap_clr,
        output mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src, reg_dst,
               mem_to_reg, shift, jump_reg, trap, state_o, retired
    );

    modport slave (
        output op, funct, mem_ready, trap_clr,
        input  mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src, reg_dst,
               mem_to_reg, shift, jump_reg, trap, state_o, retired
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with variable-latency memory handshake,
// wait-state timeout, illegal-instruction trap and retired-instruction counter.
//
// state   | meaning
// FETCH   | read instruction, IR/PC load on mem_ready
// DECODE  | register read, branch target precompute
// MEMADR  | load/store address compute
// MEMRD   | load data read, wait for mem_ready
// MEMWB   | load data to register file
// MEMWR   | store, wait for mem_ready
// EXEC_R  | R-type ALU op
// ALUWB   | R-type result to rd
// EXEC_I  | immediate ALU op
// IWB     | immediate result to rt
// BEQ/BNE | conditional PC update
// JUMP    | PC <- jump target
// JR      | PC <- A
// JAL     | PC <- jump target, $31 <- PC
// TRAP    | illegal instruction or memory timeout, wait for trap_clr
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit TRAP_EN     = 1'b1,
    parameter int RET_CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB  = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR  = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL  = 4'd9, ALU_SRA = 4'd10;

    localparam bit          TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(MEM_TIMEOUT - 1) : 16'd0;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD = 5'd3,
        S_MEMWB  = 5'd4,  S_MEMWR  = 5'd5,  S_EXEC_R = 5'd6,  S_ALUWB = 5'd7,
        S_EXEC_I = 5'd8,  S_IWB    = 5'd9,  S_BEQ    = 5'd10, S_BNE   = 5'd11,
        S_JUMP   = 5'd12, S_JR     = 5'd13, S_JAL    = 5'd14, S_TRAP  = 5'd15
    } state_t;

    state_t               state, state_next;
    logic [15:0]          wait_cnt;
    logic [RET_CNT_W-1:0] retired;
    logic                 wait_hit;

    logic       is_rtype, is_shift, is_jr, r_legal;
    logic [3:0] alu_r, alu_i;

    logic       mem_req_i, iord_i, mem_write_i, ir_write_i, pc_write_i;
    logic       branch_i, branch_ne_i, reg_write_i, alu_src_a_i, shift_i;
    logic       jump_reg_i, trap_i;
    logic [2:0] alu_src_b_i, pc_src_i, reg_dst_i, mem_to_reg_i;
    logic [3:0] alu_control_i;

    // The wait that would make the count reach MEM_TIMEOUT is the last one allowed.
    assign wait_hit = TO_EN && (wait_cnt == TO_LAST);

    always_comb begin
        is_rtype = (bus.op == OP_RTYPE);
        is_jr    = is_rtype && (bus.funct == F_JR);
        is_shift = is_rtype && (bus.funct == F_SLL || bus.funct == F_SRL || bus.funct == F_SRA);
        r_legal  = 1'b0;
        alu_r    = ALU_ADD;
        case (bus.funct)
            F_ADD, F_ADDU: begin alu_r = ALU_ADD;  r_legal = is_rtype; end
            F_SUB, F_SUBU: begin alu_r = ALU_SUB;  r_legal = is_rtype; end
            F_AND:         begin alu_r = ALU_AND;  r_legal = is_rtype; end
            F_OR:          begin alu_r = ALU_OR;   r_legal = is_rtype; end
            F_XOR:         begin alu_r = ALU_XOR;  r_legal = is_rtype; end
            F_NOR:         begin alu_r = ALU_NOR;  r_legal = is_rtype; end
            F_SLT:         begin alu_r = ALU_SLT;  r_legal = is_rtype; end
            F_SLTU:        begin alu_r = ALU_SLTU; r_legal = is_rtype; end
            F_SLL:         begin alu_r = ALU_SLL;  r_legal = is_rtype; end
            F_SRL:         begin alu_r = ALU_SRL;  r_legal = is_rtype; end
            F_SRA:         begin alu_r = ALU_SRA;  r_legal = is_rtype; end
            default:       begin alu_r = ALU_ADD;  r_legal = 1'b0;     end
        endcase
        case (bus.op)
            OP_ANDI: alu_i = ALU_AND;
            OP_ORI:  alu_i = ALU_OR;
            OP_XORI: alu_i = ALU_XOR;
            OP_SLTI: alu_i = ALU_SLT;
            default: alu_i = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= 16'd0;
            retired  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= 16'd0;
            else if (mem_req_i && !bus.mem_ready && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
            if (state_next == S_FETCH && state != S_FETCH && state != S_TRAP)
                retired <= retired + RET_CNT_W'(1);
        end
    end

    always_comb begin
        state_next    = state;
        mem_req_i     = 1'b0;
        iord_i        = 1'b0;
        mem_write_i   = 1'b0;
        ir_write_i    = 1'b0;
        pc_write_i    = 1'b0;
        branch_i      = 1'b0;
        branch_ne_i   = 1'b0;
        reg_write_i   = 1'b0;
        alu_src_a_i   = 1'b0;
        alu_src_b_i   = 3'd1;
        alu_control_i = ALU_ADD;
        pc_src_i      = 3'd0;
        reg_dst_i     = 3'd1;
        mem_to_reg_i  = 3'd0;
        shift_i       = 1'b0;
        jump_reg_i    = 1'b0;
        trap_i        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_i = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_i = 1'b1;
                    pc_write_i = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b_i = 3'd3;
                shift_i     = is_shift;
                if (is_jr)        state_next = S_JR;
                else if (r_legal) state_next = S_EXEC_R;
                else begin
                    case (bus.op)
                        OP_LW, OP_SW:                         state_next = S_MEMADR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                        OP_SLTI:                              state_next = S_EXEC_I;
                        OP_BEQ:                               state_next = S_BEQ;
                        OP_BNE:                               state_next = S_BNE;
                        OP_J:                                 state_next = S_JUMP;
                        OP_JAL:                               state_next = S_JAL;
                        default: state_next = TRAP_EN ? S_TRAP : S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a_i = 1'b1;
                alu_src_b_i = 3'd2;
                state_next  = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_i = 1'b1;
                iord_i    = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
                else if (wait_hit) state_next = S_TRAP;
            end
            S_MEMWR: begin
                mem_req_i   = 1'b1;
                iord_i      = 1'b1;
                mem_write_i = bus.mem_ready;
                if (bus.mem_ready) state_next = S_FETCH;
                else if (wait_hit) state_next = S_TRAP;
            end
            S_MEMWB: begin
                reg_write_i  = 1'b1;
                reg_dst_i    = 3'd0;
                mem_to_reg_i = 3'd1;
                state_next   = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_i   = 1'b1;
                alu_src_b_i   = is_shift ? 3'd4 : 3'd0;
                alu_control_i = alu_r;
                state_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_i = 1'b1;
                state_next  = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a_i   = 1'b1;
                alu_src_b_i   = 3'd2;
                alu_control_i = alu_i;
                state_next    = S_IWB;
            end
            S_IWB: begin
                reg_write_i = 1'b1;
                reg_dst_i   = 3'd0;
                state_next  = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                alu_src_a_i   = 1'b1;
                alu_src_b_i   = 3'd0;
                alu_control_i = ALU_SUB;
                pc_src_i      = 3'd1;
                branch_i      = (state == S_BEQ);
                branch_ne_i   = (state == S_BNE);
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write_i = 1'b1;
                pc_src_i   = 3'd2;
                state_next = S_FETCH;
            end
            S_JR: begin
                pc_write_i = 1'b1;
                jump_reg_i = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                pc_write_i   = 1'b1;
                pc_src_i     = 3'd2;
                reg_write_i  = 1'b1;
                reg_dst_i    = 3'd2;
                mem_to_reg_i = 3'd2;
                state_next   = S_FETCH;
            end
            S_TRAP: begin
                trap_i = 1'b1;
                if (bus.trap_clr) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so nothing fires while reset holds the FSM in FETCH.
    assign bus.mem_req     = mem_req_i   & rst_n;
    assign bus.mem_write   = mem_write_i & rst_n;
    assign bus.ir_write    = ir_write_i  & rst_n;
    assign bus.pc_write    = pc_write_i  & rst_n;
    assign bus.reg_write   = reg_write_i & rst_n;
    assign bus.branch      = branch_i    & rst_n;
    assign bus.branch_ne   = branch_ne_i & rst_n;
    assign bus.iord        = iord_i;
    assign bus.alu_src_a   = alu_src_a_i;
    assign bus.alu_src_b   = alu_src_b_i;
    assign bus.alu_control = alu_control_i;
    assign bus.pc_src      = pc_src_i;
    assign bus.reg_dst     = reg_dst_i;
    assign bus.mem_to_reg  = mem_to_reg_i;
    assign bus.shift       = shift_i;
    assign bus.jump_reg    = jump_reg_i;
    assign bus.trap        = trap_i;
    assign bus.state_o     = state;
    assign bus.retired     = retired;
endmodule
